// File: rtl/shift_right_stage.sv
// Purpose: registered logical right shifter (a >> b) feeding an in-order result FIFO.
// Latency: one cycle from accept to out_valid when the FIFO is empty; one accept and one pop per cycle sustained.
// Backpressure: in_ready drops only when the FIFO is full, decoded from the level register alone.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in_a is the value, in_b the unsigned shift amount
//   out_valid/out_ready result handshake; out_data = head result, out_sat = head had b >= N
//   level               FIFO occupancy, 0..DEPTH
module shift_right_stage #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_a,
  input  logic [N-1:0]             in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_data,
  output logic                     out_sat,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // One extra bit so N itself is representable for the saturation compare.
  localparam logic [N:0]    SHIFT_LIM = (N+1)'(N);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

  logic [N-1:0]     data_mem [DEPTH];
  logic [DEPTH-1:0] sat_mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             push;
  logic             pop;
  logic [N-1:0]     shift_res;
  logic             shift_sat;

  // Every bit of in_b counts: any amount >= N shifts everything out.
  always_comb begin
    shift_sat = ({1'b0, in_b} >= SHIFT_LIM);
    shift_res = '0;
    if (!shift_sat) begin
      shift_res = in_a >> in_b;
    end
  end

  // Handshake flags depend only on the level register, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = data_mem[rd_ptr];
  assign out_sat   = sat_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      sat_mem <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= shift_res;
        sat_mem[wr_ptr]  <= shift_sat;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Pointers wrap modulo DEPTH; level alone distinguishes full from empty.
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_stage.sv
// Bench for shift_right_stage (N=8, DEPTH=4): directed vector table, hand-written
// fill/drain, simultaneous push/pop, wrap and reset sequences, then random stress
// checked against a reference queue updated at each falling edge.
module tb_shift_right_stage;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_a      = 8'h00;
  logic [7:0] in_b      = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sat;
  logic [2:0] level;

  int         checks = 0;
  int         errors = 0;
  bit         sb_en  = 1'b0;
  logic [8:0] q[$];

  shift_right_stage #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_res(input logic [7:0] a, input logic [7:0] b);
    if (b >= 8'd8) return {1'b1, 8'h00};
    return {1'b0, a >> b};
  endfunction

  // Reference queue: inputs are stable around the falling edge, so the
  // handshakes seen here are exactly the ones the next rising edge takes.
  always @(negedge clk) begin
    if (!rst && sb_en) begin
      check("sb_level", {29'd0, level}, q.size());
      check("sb_out_valid", {31'd0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
      check("sb_in_ready", {31'd0, in_ready}, (q.size() < DEPTH) ? 32'd1 : 32'd0);
      if (out_valid && out_ready && q.size() != 0) begin
        check("sb_result", {23'd0, out_sat, out_data}, {23'd0, q[0]});
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_res(in_a, in_b));
      end
    end
  end

  // Presents a pair and waits (bounded) for it to be taken; returns at posedge+1.
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    bit acc;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int c = 0; c < 20 && !done; c++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got not-accepted expected accepted at %0t", $time);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_sat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit acc;
    int nlvl;

    vecs[0] = '{8'h81, 8'h02, 8'h20, 1'b0};
    vecs[1] = '{8'h4B, 8'h04, 8'h04, 1'b0};
    vecs[2] = '{8'h4B, 8'h44, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 8'h08, 8'h00, 1'b1};
    vecs[4] = '{8'hA5, 8'h00, 8'hA5, 1'b0};
    vecs[5] = '{8'hFF, 8'h07, 8'h01, 1'b0};
    vecs[6] = '{8'hC3, 8'h03, 8'h18, 1'b0};
    vecs[7] = '{8'h01, 8'h80, 8'h00, 1'b1};
    vecs[8] = '{8'h9C, 8'h09, 8'h00, 1'b1};
    vecs[9] = '{8'h80, 8'h01, 8'h40, 1'b0};

    // Reset state.
    #12;
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    sb_en = 1'b1;

    // Table: each result must be at the head one cycle after accept.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_sat", i), {31'd0, out_sat}, {31'd0, vecs[i].exp_sat});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_drained", i), {29'd0, level}, 32'd0);
    end

    // Fill to full; a fifth pair is held off and changes while blocked.
    out_ready = 1'b0;
    push(8'hF0, 8'h04);
    push(8'h81, 8'h01);
    push(8'h7E, 8'h09);
    push(8'h55, 8'h00);
    check("full_level", {29'd0, level}, 32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_a     = 8'hEE;
    in_b     = 8'h00;
    @(posedge clk);
    #1;
    in_a = 8'h3C;
    in_b = 8'h01;
    @(posedge clk);
    #1;
    check("full_hold_level", {29'd0, level}, 32'd4);
    check("full_head", {23'd0, out_sat, out_data}, {23'd0, 9'h00F});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("full_pop_level", {29'd0, level}, 32'd3);
    check("full_pop_in_ready", {31'd0, in_ready}, 32'd1);
    check("full_pop_head", {23'd0, out_sat, out_data}, {23'd0, 9'h040});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("held_accept_level", {29'd0, level}, 32'd3);
    check("drain_head2", {23'd0, out_sat, out_data}, {23'd0, 9'h100});
    @(posedge clk);
    #1;
    check("drain_head3", {23'd0, out_sat, out_data}, {23'd0, 9'h055});
    @(posedge clk);
    #1;
    check("drain_head5", {23'd0, out_sat, out_data}, {23'd0, 9'h01E});
    @(posedge clk);
    #1;
    check("drain_empty_level", {29'd0, level}, 32'd0);
    check("drain_empty_valid", {31'd0, out_valid}, 32'd0);

    // Level 2 with both handshakes in one edge.
    out_ready = 1'b0;
    push(8'h11, 8'h01);
    push(8'h22, 8'h02);
    in_valid  = 1'b1;
    in_a      = 8'h33;
    in_b      = 8'h03;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("both_level2", {29'd0, level}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("both_drained", {29'd0, level}, 32'd0);

    // 3*DEPTH back-to-back transfers; pointers wrap three times.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      in_a = 8'($urandom);
      in_b = 8'(i);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d_level", i), {29'd0, level}, 32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream_end_level", {29'd0, level}, 32'd0);

    // Asynchronous reset with three entries queued.
    out_ready = 1'b0;
    push(8'hAA, 8'h01);
    push(8'hBB, 8'h02);
    push(8'hCC, 8'h03);
    check("pre_rst_level", {29'd0, level}, 32'd3);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_level", {29'd0, level}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(8'h80, 8'h07);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_data", {24'd0, out_data}, 32'h01);
    check("post_rst_sat", {31'd0, out_sat}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Random stress; the producer holds a pair until it is taken.
    acc = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom % 4) != 0;
        in_a     = 8'($urandom);
        in_b     = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom % 10);
      end
      out_ready = ($urandom % 3) != 0;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    nlvl = q.size();
    check("stress_end_level", {29'd0, level}, 32'd0);
    check("stress_end_queue", nlvl, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
